// File: rtl/laser_pkg.sv
// Shared types, default parameters and the point-in-circle test for the laser circle placer.
// Coordinates are zero-extended to COORD_MAX_W before the distance test.
package laser_pkg;

    typedef enum logic [2:0] {
        LOAD,
        SCAN,
        UPDATE,
        FINAL,
        OUTPUT
    } state_e;

    localparam int unsigned DEF_COORD_W    = 4;
    localparam int unsigned DEF_NPTS       = 40;
    localparam int unsigned DEF_NCIRC      = 2;
    localparam int unsigned DEF_RADIUS     = 4;
    localparam int unsigned DEF_MAX_ROUNDS = 8;
    localparam int unsigned COORD_MAX_W    = 8;

    // 32-bit squares cannot overflow for coordinates up to COORD_MAX_W bits.
    function automatic logic pt_inside(input logic [COORD_MAX_W-1:0] cx,
                                       input logic [COORD_MAX_W-1:0] cy,
                                       input logic [COORD_MAX_W-1:0] px,
                                       input logic [COORD_MAX_W-1:0] py,
                                       input int unsigned r);
        logic [COORD_MAX_W-1:0] dx;
        logic [COORD_MAX_W-1:0] dy;
        int unsigned dsq;
        dx  = (cx >= px) ? cx - px : px - cx;
        dy  = (cy >= py) ? cy - py : py - cy;
        dsq = 32'(dx) * 32'(dx) + 32'(dy) * 32'(dy);
        return dsq <= r * r;
    endfunction

endpackage

// File: rtl/laser_cover_cnt.sv
// Coverage of one candidate position: which points fall inside it, and how many of those
// are not already claimed by the exclude mask.
module laser_cover_cnt
    import laser_pkg::*;
#(
    parameter int unsigned COORD_W = DEF_COORD_W,
    parameter int unsigned NPTS    = DEF_NPTS,
    parameter int unsigned RADIUS  = DEF_RADIUS,
    localparam int unsigned CNT_W  = $clog2(NPTS + 1)
) (
    input  logic [COORD_W-1:0]      cand_x,
    input  logic [COORD_W-1:0]      cand_y,
    input  logic [NPTS*COORD_W-1:0] pts_x,
    input  logic [NPTS*COORD_W-1:0] pts_y,
    input  logic [NPTS-1:0]         excl,
    output logic [NPTS-1:0]         in_mask,
    output logic [CNT_W-1:0]        count
);

    always_comb begin
        in_mask = '0;
        count   = '0;
        for (int i = 0; i < NPTS; i++) begin
            in_mask[i] = pt_inside(COORD_MAX_W'(cand_x), COORD_MAX_W'(cand_y),
                                   COORD_MAX_W'(pts_x[i*COORD_W +: COORD_W]),
                                   COORD_MAX_W'(pts_y[i*COORD_W +: COORD_W]), RADIUS);
            if (in_mask[i] && !excl[i]) count = count + 1'b1;
        end
    end

endmodule

// File: rtl/laser_multi.sv
// Greedy multi-circle placer: loads NPTS points, then repeatedly rescans every grid position
// for each circle in turn until positions settle or MAX_ROUNDS rounds have run.
module laser_multi
    import laser_pkg::*;
#(
    parameter int unsigned COORD_W    = DEF_COORD_W,
    parameter int unsigned NPTS       = DEF_NPTS,
    parameter int unsigned NCIRC      = DEF_NCIRC,
    parameter int unsigned RADIUS     = DEF_RADIUS,
    parameter int unsigned MAX_ROUNDS = DEF_MAX_ROUNDS,
    localparam int unsigned CNT_W     = $clog2(NPTS + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    input  logic [COORD_W-1:0]       X,
    input  logic [COORD_W-1:0]       Y,
    output logic                     IN_READY,
    output logic [NCIRC*COORD_W-1:0] CX,
    output logic [NCIRC*COORD_W-1:0] CY,
    output logic [CNT_W-1:0]         COVER,
    output logic                     DONE
);

    localparam int unsigned CAND_W  = 2 * COORD_W;
    localparam int unsigned K_W     = (NCIRC > 1) ? $clog2(NCIRC) : 1;
    localparam int unsigned ROUND_W = $clog2(MAX_ROUNDS + 1);
    localparam logic [CAND_W-1:0] CAND_LAST = {CAND_W{1'b1}};
    localparam logic [K_W-1:0]    CIRC_LAST = K_W'(NCIRC - 1);
    localparam logic [CNT_W-1:0]  PT_LAST   = CNT_W'(NPTS - 1);

    state_e                     state_q;
    logic [CNT_W-1:0]           npts_q;
    logic [ROUND_W-1:0]         round_q;
    logic [K_W-1:0]             circ_q;
    logic [CAND_W-1:0]          cand_q;
    logic                       changed_q;
    logic [NCIRC*COORD_W-1:0]   pos_x_q;
    logic [NCIRC*COORD_W-1:0]   pos_y_q;
    logic [NCIRC-1:0][NPTS-1:0] mask_q;
    logic [CAND_W-1:0]          best_pos_q;
    logic [CNT_W-1:0]           best_cnt_q;
    logic [NPTS-1:0]            best_mask_q;
    logic [NPTS*COORD_W-1:0]    pts_x_q;
    logic [NPTS*COORD_W-1:0]    pts_y_q;

    logic [COORD_W-1:0] cand_x, cand_y, best_x, best_y;
    logic [NPTS-1:0]    excl, in_mask, union_mask;
    logic [CNT_W-1:0]   cand_cnt, union_cnt;
    logic               pos_moved, stop;

    // Candidate index is {y, x}, so x advances fastest.
    assign cand_x = cand_q[COORD_W-1:0];
    assign cand_y = cand_q[CAND_W-1:COORD_W];
    assign best_x = best_pos_q[COORD_W-1:0];
    assign best_y = best_pos_q[CAND_W-1:COORD_W];

    always_comb begin
        excl       = '0;
        union_mask = '0;
        union_cnt  = '0;
        for (int j = 0; j < NCIRC; j++) begin
            union_mask = union_mask | mask_q[j];
            if (K_W'(j) != circ_q) excl = excl | mask_q[j];
        end
        for (int i = 0; i < NPTS; i++) union_cnt = union_cnt + CNT_W'(union_mask[i]);
    end

    assign pos_moved = (pos_x_q[circ_q*COORD_W +: COORD_W] != best_x) ||
                       (pos_y_q[circ_q*COORD_W +: COORD_W] != best_y);
    assign stop = ((round_q != '0) && !(changed_q || pos_moved)) ||
                  (32'(round_q) + 1 >= MAX_ROUNDS);

    laser_cover_cnt #(
        .COORD_W(COORD_W),
        .NPTS   (NPTS),
        .RADIUS (RADIUS)
    ) u_cover_cnt (
        .cand_x (cand_x),
        .cand_y (cand_y),
        .pts_x  (pts_x_q),
        .pts_y  (pts_y_q),
        .excl   (excl),
        .in_mask(in_mask),
        .count  (cand_cnt)
    );

    always_ff @(posedge CLK) begin
        if (state_q == LOAD && IN_VALID) begin
            pts_x_q[npts_q*COORD_W +: COORD_W] <= X;
            pts_y_q[npts_q*COORD_W +: COORD_W] <= Y;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= LOAD;
            npts_q      <= '0;
            round_q     <= '0;
            circ_q      <= '0;
            cand_q      <= '0;
            changed_q   <= 1'b0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            mask_q      <= '0;
            best_pos_q  <= '0;
            best_cnt_q  <= '0;
            best_mask_q <= '0;
            CX          <= '0;
            CY          <= '0;
            COVER       <= '0;
            DONE        <= 1'b0;
            IN_READY    <= 1'b1;
        end else begin
            DONE <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (IN_VALID) begin
                        if (npts_q == PT_LAST) begin
                            npts_q    <= '0;
                            IN_READY  <= 1'b0;
                            cand_q    <= '0;
                            circ_q    <= '0;
                            round_q   <= '0;
                            changed_q <= 1'b0;
                            state_q   <= SCAN;
                        end else begin
                            npts_q <= npts_q + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Strict compare keeps the earliest raster position on ties.
                    if (cand_q == '0 || cand_cnt > best_cnt_q) begin
                        best_pos_q  <= cand_q;
                        best_cnt_q  <= cand_cnt;
                        best_mask_q <= in_mask;
                    end
                    cand_q <= cand_q + 1'b1;
                    if (cand_q == CAND_LAST) state_q <= UPDATE;
                end
                UPDATE: begin
                    pos_x_q[circ_q*COORD_W +: COORD_W] <= best_x;
                    pos_y_q[circ_q*COORD_W +: COORD_W] <= best_y;
                    mask_q[circ_q]                     <= best_mask_q;
                    if (circ_q == CIRC_LAST) begin
                        if (stop) begin
                            state_q <= FINAL;
                        end else begin
                            round_q   <= round_q + 1'b1;
                            circ_q    <= '0;
                            changed_q <= 1'b0;
                            state_q   <= SCAN;
                        end
                    end else begin
                        circ_q    <= circ_q + 1'b1;
                        changed_q <= changed_q | pos_moved;
                        state_q   <= SCAN;
                    end
                end
                FINAL: begin
                    CX      <= pos_x_q;
                    CY      <= pos_y_q;
                    COVER   <= union_cnt;
                    state_q <= OUTPUT;
                end
                OUTPUT: begin
                    DONE     <= 1'b1;
                    IN_READY <= 1'b1;
                    state_q  <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_multi.sv
// Randomised bench for laser_multi: three parameterisations share the input bus and are
// checked against a plain-loop model of the greedy placement algorithm.
module tb_laser_multi;

    localparam int NP  = 40;
    localparam int RAD = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] x_drv = '0;
    logic [4:0] y_drv = '0;
    int         sel = 0;
    int         cyc = 0;

    logic       rdy_a, done_a, rdy_b, done_b, rdy_c, done_c;
    logic [7:0] cx_a, cy_a;
    logic [11:0] cx_b, cy_b;
    logic [4:0] cx_c, cy_c;
    logic [5:0] cov_a, cov_b, cov_c;
    logic       iv_a, iv_b, iv_c;

    assign iv_a = in_valid && (sel == 0);
    assign iv_b = in_valid && (sel == 1);
    assign iv_c = in_valid && (sel == 2);

    laser_multi u_dut_a (
        .CLK(CLK), .RST(RST), .IN_VALID(iv_a), .X(x_drv[3:0]), .Y(y_drv[3:0]),
        .IN_READY(rdy_a), .CX(cx_a), .CY(cy_a), .COVER(cov_a), .DONE(done_a)
    );

    laser_multi #(.NCIRC(3), .MAX_ROUNDS(1)) u_dut_b (
        .CLK(CLK), .RST(RST), .IN_VALID(iv_b), .X(x_drv[3:0]), .Y(y_drv[3:0]),
        .IN_READY(rdy_b), .CX(cx_b), .CY(cy_b), .COVER(cov_b), .DONE(done_b)
    );

    laser_multi #(.COORD_W(5), .NCIRC(1)) u_dut_c (
        .CLK(CLK), .RST(RST), .IN_VALID(iv_c), .X(x_drv), .Y(y_drv),
        .IN_READY(rdy_c), .CX(cx_c), .CY(cy_c), .COVER(cov_c), .DONE(done_c)
    );

    logic        rdy_m, done_m;
    logic [15:0] cx_m, cy_m;
    logic [5:0]  cov_m;

    always_comb begin
        rdy_m  = rdy_a;
        done_m = done_a;
        cx_m   = 16'(cx_a);
        cy_m   = 16'(cy_a);
        cov_m  = cov_a;
        case (sel)
            1: begin
                rdy_m = rdy_b; done_m = done_b; cx_m = 16'(cx_b); cy_m = 16'(cy_b);
                cov_m = cov_b;
            end
            2: begin
                rdy_m = rdy_c; done_m = done_c; cx_m = 16'(cx_c); cy_m = 16'(cy_c);
                cov_m = cov_c;
            end
            default: ;
        endcase
    end

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    int cw_of[3] = '{4, 4, 5};
    int nc_of[3] = '{2, 3, 1};
    int mr_of[3] = '{8, 1, 8};

    int          pts_x[NP], pts_y[NP];
    int          m_px[3][3], m_py[3][3];
    logic [63:0] m_mask[3][3];
    int          e_cx[3], e_cy[3], e_cov, e_rounds;
    int          o_cx[3], o_cy[3], o_cov, o_lat;
    int          prev_cov[3];
    logic [15:0] prev_cx[3];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            prev_cov[i] = 0;
            prev_cx[i]  = '0;
            for (int k = 0; k < 3; k++) begin
                m_px[i][k]   = 0;
                m_py[i][k]   = 0;
                m_mask[i][k] = '0;
            end
        end
    endtask

    // Greedy rounds computed directly from the placement rules.
    task automatic model_job(input int inst);
        int cw, nc, side, best, cnt, bx, by, dx, dy;
        logic [63:0] others, m, bm, uni;
        bit changed;
        cw = cw_of[inst];
        nc = nc_of[inst];
        side = 1 << cw;
        e_rounds = 0;
        for (int r = 0; r < mr_of[inst]; r++) begin
            changed = 1'b0;
            for (int k = 0; k < nc; k++) begin
                others = '0;
                for (int j = 0; j < nc; j++) if (j != k) others |= m_mask[inst][j];
                best = -1; bx = 0; by = 0; bm = '0;
                for (int py = 0; py < side; py++) begin
                    for (int px = 0; px < side; px++) begin
                        m = '0;
                        cnt = 0;
                        for (int i = 0; i < NP; i++) begin
                            dx = px - pts_x[i];
                            dy = py - pts_y[i];
                            if (dx * dx + dy * dy <= RAD * RAD) begin
                                m[i] = 1'b1;
                                if (!others[i]) cnt++;
                            end
                        end
                        if (cnt > best) begin
                            best = cnt; bx = px; by = py; bm = m;
                        end
                    end
                end
                if (bx != m_px[inst][k] || by != m_py[inst][k]) changed = 1'b1;
                m_px[inst][k] = bx;
                m_py[inst][k] = by;
                m_mask[inst][k] = bm;
            end
            e_rounds = r + 1;
            if (r >= 1 && !changed) break;
        end
        uni = '0;
        for (int k = 0; k < nc; k++) begin
            uni |= m_mask[inst][k];
            e_cx[k] = m_px[inst][k];
            e_cy[k] = m_py[inst][k];
        end
        e_cov = $countones(uni);
    endtask

    task automatic drive_points(input int inst, input bit toggle, input int extras,
                                output int acc_cyc);
        int idx, phase;
        idx = 0;
        phase = 0;
        acc_cyc = 0;
        sel = inst;
        while (idx < NP) begin
            @(negedge CLK);
            in_valid = toggle ? ((phase % 2) == 0) : 1'b1;
            phase++;
            x_drv = 5'(pts_x[idx]);
            y_drv = 5'(pts_y[idx]);
            if (in_valid) begin
                if (idx == 0 || idx == NP - 1) check("ready_load", 64'(rdy_m), 1);
                acc_cyc = cyc + 1;
                idx++;
            end
        end
        for (int e = 0; e < extras; e++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            x_drv = 5'($urandom);
            y_drv = 5'($urandom);
            check("ready_busy", 64'(rdy_m), 0);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int acc_cyc);
        int cw, nc, side2, budget, tmp;
        bit seen;
        cw = cw_of[inst];
        nc = nc_of[inst];
        side2 = 1 << (2 * cw);
        check("hold_cover", 64'(cov_m), 64'(prev_cov[inst]));
        check("hold_cx", 64'(cx_m), 64'(prev_cx[inst]));
        budget = mr_of[inst] * nc * (side2 + 1) + 20;
        seen = 1'b0;
        o_lat = -1;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge CLK);
            if (done_m) begin
                seen = 1'b1;
                o_lat = cyc - acc_cyc;
            end
        end
        check("done_seen", 64'(seen), 1);
        o_cov = int'(cov_m);
        check("cover", 64'(o_cov), 64'(e_cov));
        check("latency", 64'(o_lat), 64'(e_rounds * nc * (side2 + 1) + 2));
        prev_cx[inst] = '0;
        for (int k = 0; k < nc; k++) begin
            tmp = int'(cx_m);
            o_cx[k] = (tmp >> (k * cw)) & ((1 << cw) - 1);
            tmp = int'(cy_m);
            o_cy[k] = (tmp >> (k * cw)) & ((1 << cw) - 1);
            check($sformatf("cx%0d", k), 64'(o_cx[k]), 64'(e_cx[k]));
            check($sformatf("cy%0d", k), 64'(o_cy[k]), 64'(e_cy[k]));
            prev_cx[inst] |= 16'(e_cx[k] << (k * cw));
        end
        prev_cov[inst] = e_cov;
        @(negedge CLK);
        check("done_pulse", 64'(done_m), 0);
        check("ready_after", 64'(rdy_m), 1);
    endtask

    task automatic run_job(input int inst, input bit toggle, input int extras);
        int acc;
        drive_points(inst, toggle, extras, acc);
        model_job(inst);
        wait_done(inst, acc);
    endtask

    task automatic pts_rand(input int cw);
        for (int i = 0; i < NP; i++) begin
            pts_x[i] = int'($urandom_range((1 << cw) - 1, 0));
            pts_y[i] = int'($urandom_range((1 << cw) - 1, 0));
        end
    endtask

    task automatic pts_two(input int ax, input int ay, input int bx, input int by);
        for (int i = 0; i < NP; i++) begin
            pts_x[i] = (i < NP / 2) ? ax : bx;
            pts_y[i] = (i < NP / 2) ? ay : by;
        end
    endtask

    initial begin
        int acc;
        bit stale;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_cover", 64'(cov_a), 0);
        check("rst_cx", 64'(cx_a), 0);
        check("rst_done", 64'(done_a), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_ready_a", 64'(rdy_a), 1);
        check("rst_ready_c", 64'(rdy_c), 1);

        pts_two(5, 5, 5, 5);
        run_job(0, 1'b0, 0);
        check("single_c0x", 64'(o_cx[0]), 5);
        check("single_c0y", 64'(o_cy[0]), 1);
        check("single_c1", 64'(o_cx[1] + o_cy[1]), 0);
        check("single_cov", 64'(o_cov), 40);
        check("single_lat", 64'(o_lat), 1030);

        pts_two(2, 2, 12, 12);
        run_job(0, 1'b0, 0);
        check("pair_c0", 64'(o_cx[0] + o_cy[0]), 0);
        check("pair_c1x", 64'(o_cx[1]), 12);
        check("pair_c1y", 64'(o_cy[1]), 8);
        check("pair_cov", 64'(o_cov), 40);
        check("pair_lat", 64'(o_lat), 1030);

        pts_rand(4);
        run_job(0, 1'b1, 5);
        repeat (2) begin
            pts_rand(4);
            run_job(0, 1'b0, 0);
        end

        // Abort a job mid-scan; the next job must look like a cold start.
        pts_rand(4);
        drive_points(0, 1'b0, 0, acc);
        repeat (99) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("abort_cover", 64'(cov_a), 0);
        check("abort_cx", 64'(cx_a), 0);
        check("abort_cy", 64'(cy_a), 0);
        check("abort_done", 64'(done_a), 0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        check("abort_ready", 64'(rdy_a), 1);
        stale = 1'b0;
        repeat (1100) begin
            @(negedge CLK);
            if (done_a) stale = 1'b1;
        end
        check("abort_no_done", 64'(stale), 0);
        pts_rand(4);
        run_job(0, 1'b0, 0);

        pts_rand(4);
        run_job(1, 1'b0, 0);
        check("one_round_lat", 64'(o_lat), 773);

        pts_two(3, 3, 28, 28);
        run_job(2, 1'b0, 0);
        check("tie_cx", 64'(o_cx[0]), 1);
        check("tie_cy", 64'(o_cy[0]), 0);
        check("tie_cov", 64'(o_cov), 20);
        pts_rand(5);
        run_job(2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/laser_multi.md
LASER_MULTI -- requirements
Module: laser_multi

Interface
REQ-001 SHALL have parameter COORD_W, default 4, meaning coordinate width; the grid is 2^COORD_W x 2^COORD_W.
REQ-002 SHALL have parameter NPTS, default 40, meaning number of target points per job.
REQ-003 SHALL have parameter NCIRC, default 2, meaning number of circles placed (legal range 1..8).
REQ-004 SHALL have parameter RADIUS, default 4, meaning circle radius in grid units.
REQ-005 SHALL have parameter MAX_ROUNDS, default 8, meaning the cap on optimisation rounds.
REQ-006 SHALL have port CLK, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port IN_VALID, input, 1 bit: the point on X/Y is valid.
REQ-009 SHALL have port X, input, COORD_W bits: point x.
REQ-010 SHALL have port Y, input, COORD_W bits: point y.
REQ-011 SHALL have port IN_READY, output, 1 bit: block accepts points.
REQ-012 SHALL have port CX, output, NCIRC*COORD_W bits: circle x coordinates, circle k in bits [k*COORD_W +: COORD_W].
REQ-013 SHALL have port CY, output, NCIRC*COORD_W bits: circle y coordinates, same packing as CX.
REQ-014 SHALL have port COVER, output, clog2(NPTS+1) bits: number of points inside the union of all circles.
REQ-015 SHALL have port DONE, output, 1 bit: one-cycle result strobe.

Function
REQ-016 SHALL use the states LOAD, SCAN, UPDATE, FINAL and OUTPUT.
REQ-017 LOAD: SHALL drive IN_READY=1 and store a point on each edge where IN_VALID=1; IN_VALID=0 cycles SHALL be ignored.
REQ-018 LOAD SHALL go to SCAN on the edge that accepts point NPTS, and IN_READY SHALL be 0 from then until OUTPUT ends.
REQ-019 Point i SHALL be inside a circle at (cx,cy) iff dx*dx+dy*dy <= RADIUS*RADIUS, with dx=|cx-xi| and dy=|cy-yi|.
REQ-020 Distance arithmetic SHALL use unsigned widths of at least 2*COORD_W+1 bits and SHALL NOT overflow.
REQ-021 Each circle k SHALL keep a position (reset value (0,0)) and an NPTS-bit cover mask (reset value 0).
REQ-022 SCAN for circle k SHALL visit all 2^(2*COORD_W) candidate positions, one per cycle, in raster order: x fastest, starting at (0,0).
REQ-023 For each candidate, SCAN SHALL count the points inside the candidate that are not in the cover mask of any other circle.
REQ-024 SCAN SHALL capture the first candidate unconditionally and later candidates only on a strictly greater count, so ties keep the earliest raster position.
REQ-025 UPDATE SHALL last one cycle and SHALL write the best position and its mask into circle k.
REQ-026 UPDATE SHALL flag a change if circle k's position differs from its old value, then advance to circle k+1, or at k=NCIRC-1 end the round.
REQ-027 At round end, the block SHALL go to FINAL if round index >= 1 and no position changed in that round, or if MAX_ROUNDS rounds have completed.
REQ-028 Otherwise, round end SHALL start a new round at circle 0.
REQ-029 FINAL (1 cycle) SHALL register CX, CY and COVER, where COVER is the popcount of the OR of all masks.
REQ-030 OUTPUT (1 cycle) SHALL drive DONE=1 and then return to LOAD.
REQ-031 CX/CY/COVER SHALL hold their values until the next FINAL.
REQ-032 Latency from the last accepting edge to the DONE-high edge SHALL equal R*NCIRC*(2^(2*COORD_W)+1)+2 cycles, where R is the number of rounds run.
REQ-033 IN_VALID during non-LOAD states SHALL have no effect.
REQ-034 With NCIRC=1, termination SHALL occur after round 1 (the position cannot change).

Reset
REQ-035 RST SHALL, asynchronously at any state (including mid-SCAN), force LOAD, point count 0, round 0, all positions (0,0), all masks 0, CX=CY=0, COVER=0, DONE=0, IN_READY=1 after release.
REQ-036 Point storage SHALL NOT require reset.

Structure
REQ-037 Package laser_pkg SHALL hold the state enum, the default parameter constants, and an inside(cx,cy,px,py,r) function.
REQ-038 Sub-module laser_cover_cnt SHALL take a candidate position, all points and an exclude mask, and return the in-mask vector and the count; one instance SHALL be used.
REQ-039 The block SHALL use no multiplier beyond the squaring of COORD_W-bit values.

Verification
REQ-040 Defaults, 40 points at (5,5) -> C0=(5,1), C1=(0,0), COVER=40, 2 rounds.
REQ-041 Defaults, 20 points at (2,2) and 20 at (12,12) -> C0=(0,0), C1=(12,8), COVER=40, DONE 1030 cycles after the last accept.
REQ-042 IN_VALID toggling 1/0 for 80 cycles then held high; 45 points offered -> only the first 40 accepted, IN_READY low after the 40th, results match the 40-point reference model.
REQ-043 RST asserted at SCAN candidate 100, then a fresh job -> outputs 0 during and after reset, the new job's result equals a cold-start run, and no DONE appears from the aborted job.
REQ-044 MAX_ROUNDS=1, NCIRC=3, random points -> DONE exactly 3*257+2=773 cycles after the last accept, and COVER equals the model's union count.
REQ-045 NCIRC=1 and COORD_W=5 with points spread across 0..31 -> COVER equals the model's max single-circle coverage, and ties resolve to the earliest raster position.
